// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, parity-mode codes and divisor floor.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, ERRWAIT} state_t;
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;
  localparam logic [15:0] MIN_DIV = 16'd4;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO with occupancy count; a push while full only lands with a pop.
module uart_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     core_clk,
  input  logic                     core_rstn,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic          w_wr, w_rd, w_empty;
  assign w_empty = o_count == '0;
  assign o_full  = o_count == CW'(DEPTH);
  assign w_rd    = i_pop && !w_empty;
  assign w_wr    = i_push && (!o_full || w_rd);
  assign o_rdata = w_empty ? '0 : r_mem[r_rp];
  always_ff @(posedge core_clk)
    if (w_wr) r_mem[r_wp] <= i_wdata;
  always_ff @(posedge core_clk or negedge core_rstn)
    if (!core_rstn) begin
      r_wp    <= '0;
      r_rp    <= '0;
      o_count <= '0;
    end else begin
      r_wp    <= r_wp + AW'(w_wr);
      r_rp    <= r_rp + AW'(w_rd);
      o_count <= o_count + CW'(w_wr) - CW'(w_rd);
    end
endmodule

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: runtime-configurable UART receiver feeding a read FIFO,
// with frame/parity/overflow accounting and end-of-line detection.
module uart_rx_monitor import uart_pkg::*; #(
  parameter int         DATA_BITS  = 8,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] EOL_CHAR   = 8'h0A,
  parameter int         ERR_CNT_W  = 8
) (
  input  logic                          core_clk,
  input  logic                          core_rstn,
  input  logic                          ser_rx,
  input  logic                          rx_en,
  input  logic [15:0]                   clk_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic [ERR_CNT_W-1:0]          err_count,
  output logic                          line_done,
  input  logic                          clr
);
  state_t               r_state;
  logic [1:0]           r_sync, r_par;
  logic [15:0]          r_div, r_cnt;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_rx_prev, r_stop2, r_stop_idx, r_ferr, r_perr;
  logic                 w_rx, w_mid, w_last, w_final, w_ferr, w_push, w_full, w_wr, w_drop, w_err;
  assign w_rx    = r_sync[1];
  assign w_mid   = r_cnt == {1'b0, r_div[15:1]};
  assign w_last  = r_cnt == r_div - 16'd1;
  assign w_final = rx_en && r_state == STOP && w_mid && (r_stop_idx || !r_stop2);
  assign w_ferr  = r_ferr || !w_rx;
  assign w_push  = w_final && !w_ferr && !r_perr;
  assign w_wr    = w_push && (!w_full || rd_en);
  assign w_drop  = w_push && !w_wr;
  assign w_err   = (w_final && (w_ferr || r_perr)) || w_drop;
  assign rd_valid = fifo_count != '0;
  // The character is written on the final mid-stop edge, so it and every event appear on the next cycle.
  uart_rx_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .core_clk (core_clk),
    .core_rstn(core_rstn),
    .i_push   (w_push),
    .i_pop    (rd_en),
    .i_wdata  (r_data),
    .o_rdata  (rd_data),
    .o_count  (fifo_count),
    .o_full   (w_full)
  );
  always_ff @(posedge core_clk or negedge core_rstn)
    if (!core_rstn) begin
      r_sync     <= 2'b11;
      r_rx_prev  <= 1'b1;
      r_state    <= IDLE;
      r_div      <= MIN_DIV;
      r_cnt      <= '0;
      r_par      <= PAR_NONE;
      r_stop2    <= 1'b0;
      r_stop_idx <= 1'b0;
      r_ferr     <= 1'b0;
      r_perr     <= 1'b0;
      r_bit      <= '0;
      r_data     <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      line_done  <= 1'b0;
      overflow   <= 1'b0;
      err_count  <= '0;
    end else begin
      r_sync     <= {r_sync[0], ser_rx};
      r_rx_prev  <= w_rx;
      frame_err  <= w_final && w_ferr;
      parity_err <= w_final && r_perr;
      line_done  <= w_wr && r_data == DATA_BITS'(EOL_CHAR);
      overflow   <= !clr && (overflow || w_drop);
      err_count  <= clr ? '0 : (w_err && !(&err_count)) ? err_count + ERR_CNT_W'(1) : err_count;
      r_cnt      <= w_last ? '0 : r_cnt + 16'd1;
      if (!rx_en) r_state <= IDLE;
      else case (r_state)
        IDLE: if (r_rx_prev && !w_rx) begin
          r_state <= START;
          r_cnt   <= '0;
          r_div   <= clk_div < MIN_DIV ? MIN_DIV : clk_div;
          r_par   <= parity_mode;
          r_stop2 <= stop2;
        end
        START: if (w_mid && w_rx) r_state <= IDLE;
               else if (w_last) begin
                 r_state <= DATA;
                 r_bit   <= '0;
               end
        DATA: begin
          if (w_mid) r_data <= {w_rx, r_data[DATA_BITS-1:1]};
          if (w_last) begin
            r_bit <= r_bit + 4'd1;
            if (r_bit == 4'(DATA_BITS - 1)) begin
              r_state    <= (r_par == PAR_EVEN || r_par == PAR_ODD) ? PARITY : STOP;
              r_stop_idx <= 1'b0;
              r_ferr     <= 1'b0;
              r_perr     <= 1'b0;
            end
          end
        end
        PARITY: begin
          if (w_mid) r_perr <= ((^r_data) ^ w_rx) != (r_par == PAR_ODD);
          if (w_last) r_state <= STOP;
        end
        STOP: begin
          if (w_mid) r_ferr <= w_ferr;
          if (w_last) r_stop_idx <= 1'b1;
          if (w_final) begin
            r_state <= w_ferr ? ERRWAIT : IDLE;
            r_cnt   <= '0;
          end
        end
        ERRWAIT: if (!w_rx) r_cnt <= '0;
                 else if (w_last) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: directed scenarios plus randomized frames checked against a queue-based reference model.
module tb_uart_rx_monitor;
  localparam int DB = 8;
  localparam int FD = 16;
  logic core_clk = 1'b0, core_rstn = 1'b0, ser_rx = 1'b1, rx_en = 1'b0, stop2 = 1'b0, rd_en = 1'b0, clr = 1'b0;
  logic [15:0] clk_div = 16'd16;
  logic [1:0] parity_mode = 2'd0;
  logic [DB-1:0] rd_data;
  logic rd_valid, overflow, frame_err, parity_err, line_done;
  logic [$clog2(FD):0] fifo_count;
  logic [7:0] err_count;
  int n_chk = 0, n_fail = 0;
  int fe_cnt = 0, pe_cnt = 0, both_cnt = 0, ld_cnt = 0;
  int bp = 16, lat = -1;

  uart_rx_monitor #(.DATA_BITS(DB), .FIFO_DEPTH(FD), .EOL_CHAR(8'h0A), .ERR_CNT_W(8)) dut (
    .core_clk(core_clk), .core_rstn(core_rstn), .ser_rx(ser_rx), .rx_en(rx_en),
    .clk_div(clk_div), .parity_mode(parity_mode), .stop2(stop2), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count), .overflow(overflow),
    .frame_err(frame_err), .parity_err(parity_err), .err_count(err_count),
    .line_done(line_done), .clr(clr)
  );

  always #5 core_clk = ~core_clk;

  always @(negedge core_clk) begin
    fe_cnt   += int'(frame_err);
    pe_cnt   += int'(parity_err);
    both_cnt += int'(frame_err && parity_err);
    ld_cnt   += int'(line_done);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge core_clk);
  endtask

  task automatic cfg(input int div, input int pm, input bit s2);
    clk_div = 16'(div);
    parity_mode = 2'(pm);
    stop2 = s2;
    bp = div < 4 ? 4 : div;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  // Expected parity bit; -1 means the frame carries none.
  function automatic int pbit(input logic [DB-1:0] d, input int pm);
    return pm == 1 ? int'(^d) : pm == 2 ? int'(~^d) : -1;
  endfunction

  // The receiver decides at the middle of the last stop bit: 2 sync flops plus edge detect put
  // that edge bp/2+4 cycles after the stop bit is driven; rd_en/clr land on that edge when requested.
  task automatic send_frame(input logic [DB-1:0] d, input int par, input int nstop, input logic stop_lvl,
                            input bit pop_at, input bit clr_at, input bit scramble);
    logic [15:0] s_div;
    logic [1:0] s_par;
    logic s_stop2, rv0;
    int hit;
    s_div = clk_div;
    s_par = parity_mode;
    s_stop2 = stop2;
    hit = (nstop - 1) * bp + bp / 2 + 3;
    ser_rx = 1'b0;
    tick(bp);
    if (scramble) begin
      clk_div = 16'($urandom_range(2, 40));
      parity_mode = 2'($urandom_range(0, 3));
      stop2 = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < DB; i++) begin
      ser_rx = d[i];
      tick(bp);
    end
    if (par >= 0) begin
      ser_rx = 1'(par);
      tick(bp);
    end
    rv0 = rd_valid;
    lat = -1;
    ser_rx = stop_lvl;
    for (int i = 0; i < nstop * bp; i++) begin
      rd_en = pop_at && i == hit;
      clr = clr_at && i == hit;
      if (lat < 0 && rd_valid && !rv0) lat = i;
      tick(1);
    end
    rd_en = 1'b0;
    clr = 1'b0;
    ser_rx = 1'b1;
    clk_div = s_div;
    parity_mode = s_par;
    stop2 = s_stop2;
    tick(bp);
  endtask

  task automatic test_reset();
    core_rstn = 1'b0;
    tick(3);
    n_chk++;
    if ({rd_valid, overflow, frame_err, parity_err, line_done} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000", {rd_valid, overflow, frame_err, parity_err, line_done});
    end
    n_chk++;
    if (fifo_count !== '0 || err_count !== 8'd0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_values: count=%0d err=%0d data=%h want 0/0/00", fifo_count, err_count, rd_data);
    end
    core_rstn = 1'b1;
    rx_en = 1'b1;
    tick(4);
  endtask

  task automatic test_8n1();
    int fe0, pe0;
    fe0 = fe_cnt;
    pe0 = pe_cnt;
    cfg(16, 0, 0);
    send_frame(8'h41, -1, 1, 1'b1, 0, 0, 0);
    n_chk++;
    if (lat != bp / 2 + 4) begin
      n_fail++;
      $display("FAIL 8n1_latency: rd_valid rose %0d cycles into stop bit, want %0d", lat, bp / 2 + 4);
    end
    n_chk++;
    if (fifo_count !== 5'd1 || rd_valid !== 1'b1 || rd_data !== 8'h41) begin
      n_fail++;
      $display("FAIL 8n1_char: count=%0d valid=%b data=%h want 1/1/41", fifo_count, rd_valid, rd_data);
    end
    n_chk++;
    if (fe_cnt != fe0 || pe_cnt != pe0 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL 8n1_noerr: fe=%0d pe=%0d err=%0d want 0/0/0", fe_cnt - fe0, pe_cnt - pe0, err_count);
    end
    pop();
    n_chk++;
    if (fifo_count !== 5'd0 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL 8n1_pop: count=%0d valid=%b want 0/0", fifo_count, rd_valid);
    end
  endtask

  task automatic test_parity();
    int pe0, fe0, b0;
    pulse_clr();
    pe0 = pe_cnt;
    fe0 = fe_cnt;
    b0 = both_cnt;
    cfg(16, 1, 0);
    send_frame(8'h03, 1 - pbit(8'h03, 1), 1, 1'b1, 0, 0, 0);
    n_chk++;
    if (pe_cnt - pe0 != 1 || err_count !== 8'd1 || fifo_count !== 5'd0) begin
      n_fail++;
      $display("FAIL parity_bad: pe=%0d err=%0d count=%0d want 1/1/0", pe_cnt - pe0, err_count, fifo_count);
    end
    send_frame(8'h03, pbit(8'h03, 1), 1, 1'b1, 0, 0, 0);
    n_chk++;
    if (fifo_count !== 5'd1 || rd_data !== 8'h03 || pe_cnt - pe0 != 1) begin
      n_fail++;
      $display("FAIL parity_good: count=%0d data=%h pe=%0d want 1/03/1", fifo_count, rd_data, pe_cnt - pe0);
    end
    pop();
    send_frame(8'h03, 1 - pbit(8'h03, 1), 1, 1'b0, 0, 0, 0);
    tick(2 * bp);
    n_chk++;
    if (fe_cnt - fe0 != 1 || both_cnt - b0 != 1 || err_count !== 8'd2 || fifo_count !== 5'd0) begin
      n_fail++;
      $display("FAIL parity_frame_both: fe=%0d both=%0d err=%0d count=%0d want 1/1/2/0",
               fe_cnt - fe0, both_cnt - b0, err_count, fifo_count);
    end
    cfg(16, 2, 1);
    send_frame(8'hA5, pbit(8'hA5, 2), 2, 1'b1, 0, 0, 0);
    n_chk++;
    if (fifo_count !== 5'd1 || rd_data !== 8'hA5 || err_count !== 8'd2) begin
      n_fail++;
      $display("FAIL odd_stop2: count=%0d data=%h err=%0d want 1/a5/2", fifo_count, rd_data, err_count);
    end
    pop();
  endtask

  task automatic test_glitch_break();
    int fe0;
    logic [7:0] e0;
    cfg(16, 0, 0);
    fe0 = fe_cnt;
    e0 = err_count;
    ser_rx = 1'b0;
    tick(3);
    ser_rx = 1'b1;
    tick(3 * bp);
    n_chk++;
    if (fifo_count !== 5'd0 || fe_cnt != fe0 || err_count !== e0) begin
      n_fail++;
      $display("FAIL glitch: count=%0d fe=%0d err=%0d want 0/0/%0d", fifo_count, fe_cnt - fe0, err_count, e0);
    end
    ser_rx = 1'b0;
    tick(20 * bp);
    ser_rx = 1'b1;
    tick(2 * bp);
    n_chk++;
    if (fe_cnt - fe0 != 1 || err_count !== e0 + 8'd1 || fifo_count !== 5'd0) begin
      n_fail++;
      $display("FAIL break: fe=%0d err=%0d count=%0d want 1/%0d/0", fe_cnt - fe0, err_count, fifo_count, e0 + 8'd1);
    end
    send_frame(8'h55, -1, 1, 1'b1, 0, 0, 0);
    n_chk++;
    if (fifo_count !== 5'd1 || rd_data !== 8'h55) begin
      n_fail++;
      $display("FAIL break_recover: count=%0d data=%h want 1/55", fifo_count, rd_data);
    end
    pop();
  endtask

  task automatic test_overflow();
    logic [DB-1:0] d [17];
    logic [DB-1:0] x;
    logic [DB-1:0] q [$];
    pulse_clr();
    cfg(8, 0, 0);
    for (int i = 0; i < 17; i++) begin
      d[i] = DB'($urandom);
      send_frame(d[i], -1, 1, 1'b1, 0, 0, 0);
      if (i > 0 && i < 16) q.push_back(d[i]);
    end
    n_chk++;
    if (fifo_count !== 5'd16 || overflow !== 1'b1 || err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL overflow: count=%0d ovf=%b err=%0d want 16/1/1", fifo_count, overflow, err_count);
    end
    x = DB'($urandom);
    q.push_back(x);
    send_frame(x, -1, 1, 1'b1, 1, 0, 0);
    n_chk++;
    if (fifo_count !== 5'd16 || err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL full_push_pop: count=%0d err=%0d want 16/1", fifo_count, err_count);
    end
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if (rd_valid !== 1'b1 || rd_data !== q[i]) begin
        n_fail++;
        $display("FAIL overflow_order[%0d]: valid=%b data=%h want 1/%h", i, rd_valid, rd_data, q[i]);
      end
      pop();
    end
    pop();
    n_chk++;
    if (fifo_count !== 5'd0 || rd_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_pop: count=%0d valid=%b ovf=%b want 0/0/1", fifo_count, rd_valid, overflow);
    end
    pulse_clr();
    n_chk++;
    if (overflow !== 1'b0 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL clr: ovf=%b err=%0d want 0/0", overflow, err_count);
    end
  endtask

  task automatic test_line_end();
    int ld0, pe0;
    logic [7:0] s [3];
    s[0] = 8'h4F;
    s[1] = 8'h4B;
    s[2] = 8'h0A;
    cfg(16, 0, 0);
    ld0 = ld_cnt;
    send_frame(s[0], -1, 1, 1'b1, 0, 0, 0);
    send_frame(s[1], -1, 1, 1'b1, 0, 0, 0);
    n_chk++;
    if (ld_cnt != ld0) begin
      n_fail++;
      $display("FAIL line_early: line_done pulses=%0d want 0", ld_cnt - ld0);
    end
    send_frame(s[2], -1, 1, 1'b1, 0, 0, 0);
    n_chk++;
    if (ld_cnt - ld0 != 1) begin
      n_fail++;
      $display("FAIL line_done: pulses=%0d want 1", ld_cnt - ld0);
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (rd_data !== s[i]) begin
        n_fail++;
        $display("FAIL line_data[%0d]: got %h want %h", i, rd_data, s[i]);
      end
      pop();
    end
    pulse_clr();
    pe0 = pe_cnt;
    cfg(16, 1, 0);
    send_frame(8'h03, 1 - pbit(8'h03, 1), 1, 1'b1, 0, 0, 0);
    send_frame(8'h03, 1 - pbit(8'h03, 1), 1, 1'b1, 0, 1, 0);
    n_chk++;
    if (pe_cnt - pe0 != 2 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL clr_vs_err: pe=%0d err=%0d want 2/0", pe_cnt - pe0, err_count);
    end
  endtask

  task automatic test_midframe();
    int fe0, pe0;
    logic [7:0] e0;
    cfg(16, 0, 0);
    send_frame(8'h11, -1, 1, 1'b1, 0, 0, 0);
    fe0 = fe_cnt;
    pe0 = pe_cnt;
    e0 = err_count;
    ser_rx = 1'b0;
    tick(bp);
    for (int i = 0; i < 3; i++) tick(bp);
    ser_rx = 1'b1;
    tick(bp / 2);
    rx_en = 1'b0;
    tick(7 * bp);
    rx_en = 1'b1;
    tick(2 * bp);
    n_chk++;
    if (fifo_count !== 5'd1 || rd_data !== 8'h11 || fe_cnt != fe0 || pe_cnt != pe0 || err_count !== e0) begin
      n_fail++;
      $display("FAIL rx_en_abort: count=%0d data=%h fe=%0d pe=%0d err=%0d want 1/11/0/0/%0d",
               fifo_count, rd_data, fe_cnt - fe0, pe_cnt - pe0, err_count, e0);
    end
    cfg(16, 1, 0);
    send_frame(8'h03, 1 - pbit(8'h03, 1), 1, 1'b1, 0, 0, 0);
    cfg(16, 0, 0);
    ser_rx = 1'b0;
    tick(bp);
    ser_rx = 1'b1;
    tick(bp / 2);
    core_rstn = 1'b0;
    #1;
    n_chk++;
    if ({rd_valid, overflow, frame_err, parity_err, line_done} !== 5'b0 || fifo_count !== '0 ||
        err_count !== 8'd0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b count=%0d err=%0d data=%h want all 0", rd_valid, fifo_count, err_count, rd_data);
    end
    tick(2);
    core_rstn = 1'b1;
    tick(2 * bp);
    send_frame(8'h5A, -1, 1, 1'b1, 0, 0, 0);
    n_chk++;
    if (fifo_count !== 5'd1 || rd_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL after_reset: count=%0d data=%h want 1/5a", fifo_count, rd_data);
    end
    pop();
  endtask

  task automatic test_random();
    logic [DB-1:0] q [$];
    logic [DB-1:0] d, exp;
    int pe0, ld0, bad_n, ld_exp, div, pm, p;
    bit s2, bad;
    pulse_clr();
    pe0 = pe_cnt;
    ld0 = ld_cnt;
    bad_n = 0;
    ld_exp = 0;
    for (int i = 0; i < 12; i++) begin
      div = $urandom_range(2, 20);
      pm = $urandom_range(0, 3);
      s2 = 1'($urandom_range(0, 1));
      d = (i == 5) ? 8'h0A : DB'($urandom);
      bad = (pm == 1 || pm == 2) && $urandom_range(0, 2) == 0;
      cfg(div, pm, s2);
      p = pbit(d, pm);
      if (bad) p = 1 - p;
      send_frame(d, p, s2 ? 2 : 1, 1'b1, 0, 0, 1);
      tick(bp);
      if (bad) bad_n++;
      else begin
        q.push_back(d);
        ld_exp += int'(d == 8'h0A);
      end
    end
    n_chk++;
    if (err_count !== 8'(bad_n) || pe_cnt - pe0 != bad_n) begin
      n_fail++;
      $display("FAIL rand_errs: err=%0d pe=%0d want %0d", err_count, pe_cnt - pe0, bad_n);
    end
    n_chk++;
    if (int'(fifo_count) != q.size() || ld_cnt - ld0 != ld_exp) begin
      n_fail++;
      $display("FAIL rand_count: count=%0d ld=%0d want %0d/%0d", fifo_count, ld_cnt - ld0, q.size(), ld_exp);
    end
    while (q.size() > 0) begin
      exp = q.pop_front();
      n_chk++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        n_fail++;
        $display("FAIL rand_data: valid=%b data=%h want 1/%h", rd_valid, rd_data, exp);
      end
      pop();
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_glitch_break();
    test_overflow();
    test_line_end();
    test_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
Parametrised UART receive engine with an output FIFO and error and line accounting, used by the management-SoC DV benches and available as synthesizable RTL.
- Supersedes the fixed-format serial monitor: runtime baud divisor, configurable data width, parity and stop bits, and a buffered read interface.
- Sits on a ser_tx net of mgmt_core_wrapper, or on any GPIO-muxed serial line.
- Reports received characters, framing and parity errors, FIFO overflow, and end-of-line events.

Parameters:
DATA_BITS, 8, character width (5..9)
FIFO_DEPTH, 16, receive FIFO entries (power of two, >=2)
EOL_CHAR, 8'h0A, character that raises line_done
ERR_CNT_W, 8, width of the saturating error counter

Ports:
core_clk  in  1  system clock
core_rstn  in  1  asynchronous active-low reset
ser_rx  in  1  serial input (asynchronous to core_clk; idle high)
rx_en  in  1  receiver enable
clk_div  in  16  bit period in core_clk cycles
parity_mode  in  2  0=none, 1=even, 2=odd, 3=none
stop2  in  1  1 = two stop bits
rd_en  in  1  pop FIFO head
rd_data  out  DATA_BITS  FIFO head (valid when rd_valid)
rd_valid  out  1  FIFO non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
overflow  out  1  sticky; a character was dropped because the FIFO was full
frame_err  out  1  one-cycle pulse on a stop-bit error
parity_err  out  1  one-cycle pulse on a parity mismatch
err_count  out  ERR_CNT_W  saturating count of frame, parity and overflow events
line_done  out  1  one-cycle pulse when EOL_CHAR is pushed
clr  in  1  synchronous clear of overflow and err_count

Behaviour:
Clock, reset and timing
- ser_rx passes through a 2-flop synchronizer; all logic uses the synchronized value.
- Reset values: all outputs 0, rd_data 0, FSM in IDLE, FIFO empty.
- clk_div and the mode inputs are latched at start-bit detection; changes mid-frame have no effect until the next frame.
- A latched divisor below 4 is treated as 4.
- Bit counter runs 0..div-1; bits are sampled at count div/2 (integer division).

FSM: IDLE -> START -> DATA -> PARITY (only if parity enabled) -> STOP -> IDLE
- IDLE: wait for rx_en=1 and a synchronized high-to-low transition.
- START: at mid-bit, if the line is high it is a false start; return to IDLE with no event.
- DATA: DATA_BITS samples, LSB first.
- PARITY: even mode requires XOR(data, parity bit)=0; odd mode requires 1.
- STOP: one or two stop samples (stop2). Any low stop sample is a frame error.
- ERRWAIT (entered after a frame error): wait until the line reads high for one full bit period, then go to IDLE. This handles a break condition.

Character push
- A character is pushed one cycle after the final mid-stop sample, only if there is no frame or parity error.
- Frame and parity errors: the character is discarded, the matching pulse fires in that cycle, and err_count increments. If both errors occur, frame_err and parity_err pulse together and err_count increments once.

FIFO
- Push while full with no simultaneous pop: the character is dropped, overflow is set, and err_count increments.
- Push and pop in the same cycle while full: both succeed and fifo_count is unchanged.
- Pop while empty is ignored.
- rd_data is combinational from the head entry.
- Read and write pointers wrap modulo FIFO_DEPTH.

Other controls
- line_done pulses in the push cycle of EOL_CHAR. EOL_CHAR is compared on the low DATA_BITS bits.
- err_count saturates at all-ones.
- clr zeroes err_count and overflow. If clr coincides with an error, clr wins for that cycle.
- rx_en deasserted mid-frame: the frame is aborted, the FSM returns to IDLE next cycle, and no events are raised. The FIFO contents are kept.
- Asynchronous reset mid-frame: all state clears immediately and no partial character is pushed.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP, ERRWAIT)
  - parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD)
  - the MIN_DIV=4 constant
- One sub-module, uart_rx_fifo: parametrised synchronous FIFO with push, pop, count and full, with the same clock and reset.

Test Plan:
- 8N1 character: clk_div=16, send 0x41 -> rd_valid=1 with rd_data=0x41 one cycle after the mid-stop sample; fifo_count=1; no error pulses.
- Even parity: parity_mode=1, send 0x03 with the parity bit forced to 1 -> parity_err pulses, err_count=1, FIFO stays empty. Resend with the correct parity bit -> 0x03 is pushed.
- Glitch and break: a 3-cycle low glitch -> no push. Line held low for 20 bit periods -> exactly one frame_err, then the FSM recovers and receives a following 0x55 correctly.
- Overflow: FIFO_DEPTH=16, send 17 characters without reads -> overflow=1, err_count=1, first 16 characters read back in order. Push and pop in the same cycle while full -> count stays 16.
- Line end: send "OK\n" -> line_done pulses once, on the push of 0x0A. clr asserted together with a parity error -> err_count=0.
- Mid-frame control: rx_en dropped during data bit 3 -> no push and no error. core_rstn asserted mid-frame -> all outputs 0, and the next character is received correctly.
